// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined WIDTH-bit adder/subtractor with carry/borrow-in. The carry
//   chain is split into STAGES equal slices of SW = WIDTH/STAGES bits. Each
//   slice is added in its own register stage, using the carry registered by
//   the stage before it. Operand bits that have not been added yet move
//   forward with the transaction. Sum slices that are already done move
//   forward with it too.
//
//   Flow control uses one global advance signal. When the output holds a
//   valid result that downstream does not take, every stage holds, including
//   its valid bit. Otherwise every stage shifts by one position. Bubbles stay
//   where they are and are not removed.
//
//   Latency: a transaction accepted on edge n is visible on S/C_OUT/OUT_VALID
//   after edge n+STAGES-1.
//
// Optional feature:
//   PIPE_ADDER_OVF_EN - adds the OVF output. OVF is the signed overflow of
//   the top slice. It is registered and stays aligned with S.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset; clears valid bits, S, C_OUT, OVF
//   IN_VALID   operand set present
//   IN_READY   operands accepted this cycle (combinational from OUT_READY)
//   A, B       WIDTH-bit operands
//   C_IN       carry-in (SUB=0) or borrow-in (SUB=1)
//   SUB        0: A+B+C_IN, 1: A-B-C_IN
//   OUT_VALID  result present
//   OUT_READY  downstream accepts result
//   S          WIDTH-bit sum/difference
//   C_OUT      carry-out (SUB=0) or not-borrow (SUB=1)
//   OVF        signed overflow (only with PIPE_ADDER_OVF_EN)

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
`ifdef PIPE_ADDER_OVF_EN
    output logic             C_OUT,
    output logic             OVF
`else
    output logic             C_OUT
`endif
);

    localparam int SW = WIDTH / STAGES;

    logic              adv;
    logic              accept;

    // Per-stage state. Entry k holds the transaction after slice k is added.
    // Bits above slice k in a_q/b_q are operands still waiting to be added.
    // Bits up to slice k in s_q are finished sum bits.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
`ifdef PIPE_ADDER_OVF_EN
    logic              ovf_q;
    logic              ovf_d;
`endif

    // Scratch values for the stage being evaluated inside the loop.
    logic [WIDTH-1:0]  a_src;
    logic [WIDTH-1:0]  b_src;
    logic [WIDTH-1:0]  s_src;
    logic [WIDTH-1:0]  s_next;
    logic              c_src;
    logic              v_src;
    logic [SW:0]       slice_sum;

    always_comb begin
        adv    = ~vld_q[STAGES-1] | OUT_READY;
        accept = IN_VALID & adv;

        a_src     = '0;
        b_src     = '0;
        s_src     = '0;
        s_next    = '0;
        c_src     = 1'b0;
        v_src     = 1'b0;
        slice_sum = '0;
        c_d       = c_q;
        vld_d     = vld_q;
`ifdef PIPE_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif

        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];

            if (k == 0) begin
                // Subtraction is done as A + ~B + ~C_IN. This makes C_OUT a
                // not-borrow flag.
                a_src = A;
                b_src = SUB ? ~B : B;
                s_src = '0;
                c_src = SUB ? ~C_IN : C_IN;
                v_src = accept;
            end else begin
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                s_src = s_q[k-1];
                c_src = c_q[k-1];
                v_src = vld_q[k-1];
            end

            slice_sum = {1'b0, a_src[k*SW +: SW]}
                      + {1'b0, b_src[k*SW +: SW]}
                      + {{SW{1'b0}}, c_src};
            s_next             = s_src;
            s_next[k*SW +: SW] = slice_sum[SW-1:0];

            if (adv) begin
                a_d[k]   = a_src;
                b_d[k]   = b_src;
                s_d[k]   = s_next;
                c_d[k]   = slice_sum[SW];
                vld_d[k] = v_src;
`ifdef PIPE_ADDER_OVF_EN
                // Carry into the MSB is a^b^sum at the MSB position.
                // Overflow is that carry XOR the carry out of the slice.
                if (k == STAGES - 1) begin
                    ovf_d = a_src[WIDTH-1] ^ b_src[WIDTH-1]
                          ^ slice_sum[SW-1] ^ slice_sum[SW];
                end
`endif
            end
        end
    end

    // Operand skew registers: no reset needed, their contents are qualified
    // by the valid bits.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
        end
    end

    // Valid bits, carries and sum slices: cleared immediately by reset so the
    // output reads zero while RST_N is low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
            c_q   <= '0;
            vld_q <= '0;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
            c_q   <= c_d;
            vld_q <= vld_d;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign IN_READY  = adv;
    assign OUT_VALID = vld_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign C_OUT     = c_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Bench for pipelined_adder with WIDTH=8, STAGES=2. An arithmetic reference
//   model feeds a scoreboard queue. The queue is pushed on every accept and
//   popped on every output transfer. Directed sequences also check latency,
//   stall behaviour and reset.

module tb_pipelined_adder;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
        .C_IN      (c_in),
        .SUB       (sub),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .S         (s),
`ifdef PIPE_ADDER_OVF_EN
        .C_OUT     (c_out),
        .OVF       (ovf)
`else
        .C_OUT     (c_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. It returns {ovf, c_out, s[7:0]} from plain integer
    // arithmetic.
    function automatic logic [9:0] ref_model(input logic [7:0] op_a, input logic [7:0] op_b,
                                             input logic cin, input logic op_sub);
        int ua, ub, sa, sb, r, sr;
        logic co, ov;
        logic [7:0] res;
        ua = int'(op_a);
        ub = int'(op_b);
        sa = int'($signed(op_a));
        sb = int'($signed(op_b));
        if (op_sub) begin
            r  = ua - ub - int'(cin);
            sr = sa - sb - int'(cin);
            co = (r >= 0);
        end else begin
            r  = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            co = (r > 255);
        end
        res = 8'(r);
        ov  = (sr > 127) || (sr < -128);
        return {ov, co, res};
    endfunction

    // Scoreboard monitor. It samples on the falling edge, where inputs and
    // outputs are stable before the next rising edge.
    logic [9:0]       exp_q[$];
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    int               n_acc = 0;
    int               n_xfer = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_val("stall_valid", int'(out_valid), 1);
                check_val("stall_s", int'(s), int'(held_s));
                check_val("stall_c", int'(c_out), int'(held_c));
            end
            if (out_valid && out_ready) begin
                logic [9:0] e;
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sb_s", int'(s), int'(e[7:0]));
                    check_val("sb_c", int'(c_out), int'(e[8]));
`ifdef PIPE_ADDER_OVF_EN
                    check_val("sb_ovf", int'(ovf), int'(e[9]));
`endif
                end
            end
            prev_hold = out_valid && !out_ready;
            held_s    = s;
            held_c    = c_out;
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back(ref_model(a, b, c_in, sub));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction into an empty pipeline with OUT_READY=1. The result
    // must appear exactly two rising edges after the operands are presented.
    task automatic run_one(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                           input logic cin, input logic op_sub,
                           input logic [7:0] exp_s, input logic exp_c, input logic exp_ovf);
        int edges;
        out_ready = 1'b1;
        a = op_a; b = op_b; c_in = cin; sub = op_sub; in_valid = 1'b1;
        edges = 0;
        while (edges < 10) begin
            step();
            edges++;
            in_valid = 1'b0;
            if (out_valid) break;
        end
        check_val({tag, "_lat"}, edges, 2);
        check_val({tag, "_s"}, int'(s), int'(exp_s));
        check_val({tag, "_c"}, int'(c_out), int'(exp_c));
`ifdef PIPE_ADDER_OVF_EN
        check_val({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check_val({tag, "_ovfx"}, 0, 1);
`endif
        step();
    endtask

    task automatic drain(input string tag);
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin
            step();
            k++;
        end
        check_val({tag, "_empty"}, exp_q.size(), 0);
        check_val({tag, "_acc_eq_xfer"}, n_xfer, n_acc);
    endtask

    logic [7:0] b2b_a [4];
    logic [7:0] b2b_s [4];
    logic       b2b_c [4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        #3;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_s", int'(s), 0);
        check_val("rst_c", int'(c_out), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        step(); step();
        rst_n = 1'b1;

        // Basic add, inter-slice carry, subtract with and without borrow-in.
        run_one("add_0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_one("add_ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_one("sub_0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_one("sub_0705", 8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);

        // Back-to-back accepts with OUT_READY=1.
        b2b_a[0] = 8'h01; b2b_a[1] = 8'h02; b2b_a[2] = 8'h03; b2b_a[3] = 8'h80;
        b2b_s[0] = 8'h02; b2b_s[1] = 8'h04; b2b_s[2] = 8'h06; b2b_s[3] = 8'h00;
        b2b_c[0] = 1'b0;  b2b_c[1] = 1'b0;  b2b_c[2] = 1'b0;  b2b_c[3] = 1'b1;
        out_ready = 1'b1; sub = 1'b0; c_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin
                a = b2b_a[i]; b = b2b_a[i];
            end
            step();
            if (i >= 1) begin
                check_val("b2b_valid", int'(out_valid), 1);
                check_val("b2b_s", int'(s), int'(b2b_s[i-1]));
                check_val("b2b_c", int'(c_out), int'(b2b_c[i-1]));
            end
        end
        in_valid = 1'b0;
        step();
        check_val("b2b_tail_valid", int'(out_valid), 0);

        // Fill with OUT_READY=0, stall 5 cycles with changing operands, release.
        out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; c_in = 1'b0;
        a = 8'h11; b = 8'h22; step();
        a = 8'h33; b = 8'h44; step();
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            step();
            check_val("stall_in_ready", int'(in_ready), 0);
            check_val("stall_head_s", int'(s), 32'h33);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain("stall");

        // Reset with two transactions in flight.
        out_ready = 1'b1; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        a = 8'h21; b = 8'h21; step();
        a = 8'h42; b = 8'h01; step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        n_acc = 0; n_xfer = 0;
        #1;
        check_val("midrst_out_valid", int'(out_valid), 0);
        check_val("midrst_s", int'(s), 0);
        check_val("midrst_in_ready", int'(in_ready), 1);
        step();
        rst_n = 1'b1;
        run_one("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        step();
        check_val("post_rst_idle", int'(out_valid), 0);

        // Signed overflow cases (S/C_OUT checked in every build).
        run_one("ovf_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_one("ovf_80ff", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_one("ovf_1020", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a    = 8'($urandom);
            b    = 8'($urandom);
            c_in = 1'($urandom);
            sub  = 1'($urandom);
            step();
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
